// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register; registers D outputs one cycle after rvalid.
// A response that arrives under stallD is parked in a skid word and no new request issues until it drains.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic        imem_timeout
);

  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] skid_q, skid_d;
  logic        valid_q, valid_d;
  logic        req_q;
  logic        to_q, to_d;
  logic [7:0]  wait_q, wait_d;
  logic        in_req, got, adv;

  always_comb begin
    in_req  = (state_q == S_REQ) && req_q;
    got     = in_req && imem_rvalid;
    adv     = (got || (state_q == S_HOLD)) && !stallD;

    pc_d    = pc_q;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    skid_d  = skid_q;
    state_d = state_q;
    valid_d = 1'b0;

    if (adv) begin
      pc_d    = npc;
      state_d = S_REQ;
      instr_d = (state_q == S_HOLD) ? skid_q : imem_rdata;
      pcd_d   = pc_q;
      valid_d = 1'b1;
    end else if (got) begin
      skid_d  = imem_rdata;
      state_d = S_HOLD;
    end

    // Flush only clears the D register; pcF, state and skid follow the rules above.
    if (flushD) begin
      instr_d = 32'h0;
      pcd_d   = 32'h0;
      valid_d = 1'b0;
    end

    if (imem_rvalid) begin
      wait_d = 8'd0;
    end else if (in_req && (wait_q != TO_MAX)) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
    to_d = to_q || (wait_d == TO_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pcd_q   <= 32'h0;
      skid_q  <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      to_q    <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      req_q   <= (state_d == S_REQ);
      to_q    <= to_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_req     = req_q && !rst;
  assign imem_addr    = pc_q;
  assign pcF          = pc_q;
  assign instrD       = instr_q;
  assign pcD          = pcd_q;
  assign validD       = valid_q;
  assign imem_timeout = to_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a delivery-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          TO     = 255;

  logic        clk = 1'b0;
  logic        rst, stallD, flushD, imem_rvalid;
  logic [31:0] npc, imem_rdata;
  logic        imem_req, validD, imem_timeout;
  logic [31:0] imem_addr, pcF, instrD, pcD;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what decode should see, in terms of "a fetched word is waiting or not".
  logic [31:0] m_pc, m_instr, m_pcd, m_skid;
  logic        m_valid, m_to, m_buffered, m_req;
  int          m_wait;

  fetch_stage #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .npc(npc), .stallD(stallD), .flushD(flushD),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .pcF(pcF), .instrD(instrD),
    .pcD(pcD), .validD(validD), .imem_timeout(imem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2400_0000;
  endfunction

  task automatic model_step(input logic r, input logic rv, input logic [31:0] rd,
                            input logic st, input logic fl, input logic [31:0] np);
    logic        have, deliver;
    logic [31:0] word;
    if (r) begin
      m_pc = RST_PC; m_instr = 0; m_pcd = 0; m_valid = 0; m_to = 0;
      m_wait = 0; m_buffered = 0; m_req = 0; m_skid = 0;
      return;
    end
    have    = m_buffered || (m_req && rv);
    word    = m_buffered ? m_skid : rd;
    deliver = have && !st;
    m_valid = deliver && !fl;
    if (deliver) begin
      if (!fl) begin
        m_instr = word;
        m_pcd   = m_pc;
      end
      m_pc       = np;
      m_buffered = 0;
    end else if (have) begin
      m_skid     = word;
      m_buffered = 1;
    end
    if (fl) begin
      m_instr = 0;
      m_pcd   = 0;
    end
    if (rv) m_wait = 0;
    else if (m_req && m_wait < TO) m_wait = m_wait + 1;
    if (m_wait == TO) m_to = 1;
    m_req = !m_buffered;
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [31:0] rd,
                       input logic st, input logic fl, input logic [31:0] np);
    rst = r; imem_rvalid = rv; imem_rdata = rd; stallD = st; flushD = fl; npc = np;
    @(posedge clk);
    model_step(r, rv, rd, st, fl, np);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 32'hBAD0_BAD0, 0, 0, RST_PC);
  endtask

  task automatic test_reset();
    do_reset();
    cycle(0, 0, 0, 0, 0, RST_PC + 4);
    cycle(0, 0, 0, 0, 0, RST_PC + 4);
    cycle(1, 0, 0, 0, 0, 32'h0000_4000);
    n_checks++;
    if ({pcF, instrD, pcD, validD, imem_req, imem_timeout} !== {RST_PC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: pcF=%h instrD=%h pcD=%h validD=%b req=%b to=%b, want pcF=%h rest 0",
               pcF, instrD, pcD, validD, imem_req, imem_timeout, RST_PC);
    end
    cycle(0, 0, 0, 0, 0, RST_PC + 4);
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, RST_PC}) begin
      n_fail++;
      $display("FAIL reset_release_req: req=%b addr=%h, want 1 %h", imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] words [3];
    logic [31:0] pc;
    words[0] = 32'h2408_0001; words[1] = 32'h2409_0002; words[2] = 32'h240A_0003;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pc = RST_PC + 32'(4 * i);
      n_checks++;
      if ({imem_req, imem_addr, pcF} !== {1'b1, pc, pc}) begin
        n_fail++;
        $display("FAIL zero_wait_req[%0d]: req=%b addr=%h pcF=%h, want 1 %h", i, imem_req, imem_addr, pcF, pc);
      end
      cycle(0, 1, words[i], 0, 0, pc + 4);
      n_checks++;
      if ({pcF, instrD, pcD, validD} !== {pc + 32'd4, words[i], pc, 1'b1}) begin
        n_fail++;
        $display("FAIL zero_wait_d[%0d]: pcF=%h instrD=%h pcD=%h v=%b, want %h %h %h 1",
                 i, pcF, instrD, pcD, validD, pc + 32'd4, words[i], pc);
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] pc, prev;
    do_reset();
    prev = 32'h0;
    for (int f = 0; f < 2; f++) begin
      pc = RST_PC + 32'(4 * f);
      for (int w = 0; w < 3; w++) begin
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, pc}) begin
          n_fail++;
          $display("FAIL latency_addr[%0d.%0d]: req=%b addr=%h, want 1 %h", f, w, imem_req, imem_addr, pc);
        end
        cycle(0, w == 2, (w == 2) ? 32'h2000_0000 + 32'(f) : 32'hFFFF_FFFF, 0, 0, pc + 4);
        n_checks++;
        if (w < 2 && {validD, instrD} !== {1'b0, prev}) begin
          n_fail++;
          $display("FAIL latency_wait[%0d.%0d]: v=%b instrD=%h, want 0 %h", f, w, validD, instrD, prev);
        end else if (w == 2 && {validD, instrD, pcD} !== {1'b1, 32'h2000_0000 + 32'(f), pc}) begin
          n_fail++;
          $display("FAIL latency_done[%0d]: v=%b instrD=%h pcD=%h, want 1 %h %h",
                   f, validD, instrD, pcD, 32'h2000_0000 + 32'(f), pc);
        end
      end
      prev = 32'h2000_0000 + 32'(f);
    end
  endtask

  task automatic test_branch_wait();
    logic [31:0] beq, slot;
    beq  = 32'h1000_0003;
    slot = 32'h2408_0055;
    do_reset();
    cycle(0, 1, beq, 0, 0, RST_PC + 4);
    for (int w = 0; w < 4; w++) begin
      cycle(0, 0, 32'hFFFF_FFFF, 0, 0, 32'h0000_3010);
      n_checks++;
      if ({instrD, pcD, validD, pcF} !== {beq, RST_PC, 1'b0, RST_PC + 32'd4}) begin
        n_fail++;
        $display("FAIL branch_hold[%0d]: instrD=%h pcD=%h v=%b pcF=%h, want %h %h 0 %h",
                 w, instrD, pcD, validD, pcF, beq, RST_PC, RST_PC + 32'd4);
      end
    end
    cycle(0, 1, slot, 0, 0, 32'h0000_3010);
    n_checks++;
    if ({pcF, pcD, instrD, validD} !== {32'h0000_3010, 32'h0000_3004, slot, 1'b1}) begin
      n_fail++;
      $display("FAIL branch_slot: pcF=%h pcD=%h instrD=%h v=%b, want 3010 3004 %h 1", pcF, pcD, instrD, validD, slot);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] word;
    word = 32'h8C08_0010;
    do_reset();
    cycle(0, 1, word, 1, 0, RST_PC + 4);
    cycle(0, 0, 32'hFFFF_FFFF, 1, 0, RST_PC + 4);
    n_checks++;
    if ({imem_req, validD, pcF, instrD} !== {1'b0, 1'b0, RST_PC, 32'h0}) begin
      n_fail++;
      $display("FAIL stall_hold: req=%b v=%b pcF=%h instrD=%h, want 0 0 %h 0", imem_req, validD, pcF, instrD, RST_PC);
    end
    cycle(0, 0, 32'hFFFF_FFFF, 0, 0, RST_PC + 4);
    n_checks++;
    if ({instrD, pcD, validD, pcF, imem_req} !== {word, RST_PC, 1'b1, RST_PC + 32'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_release: instrD=%h pcD=%h v=%b pcF=%h req=%b, want %h %h 1 %h 1",
               instrD, pcD, validD, pcF, imem_req, word, RST_PC, RST_PC + 32'd4);
    end
  endtask

  task automatic test_flush_adv();
    do_reset();
    cycle(0, 1, 32'h2408_0001, 0, 0, RST_PC + 4);
    cycle(0, 1, 32'h2409_0002, 0, 1, 32'h0000_3020);
    n_checks++;
    if ({instrD, pcD, validD, pcF} !== {32'h0, 32'h0, 1'b0, 32'h0000_3020}) begin
      n_fail++;
      $display("FAIL flush_adv: instrD=%h pcD=%h v=%b pcF=%h, want 0 0 0 3020", instrD, pcD, validD, pcF);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0, 0, RST_PC + 4);
    n_checks++;
    if (imem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: to=%b, want 0", imem_timeout);
    end
    cycle(0, 0, 0, 0, 0, RST_PC + 4);
    n_checks++;
    if (imem_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_reach: to=%b, want 1", imem_timeout);
    end
    cycle(0, 1, 32'h1234_5678, 0, 0, RST_PC + 4);
    cycle(0, 1, 32'h1234_5679, 0, 0, RST_PC + 8);
    n_checks++;
    if ({imem_timeout, pcF, validD} !== {1'b1, RST_PC + 32'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_sticky: to=%b pcF=%h v=%b, want 1 %h 1", imem_timeout, pcF, validD, RST_PC + 32'd8);
    end
    cycle(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (imem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: to=%b, want 0", imem_timeout);
    end
  endtask

  task automatic test_random();
    logic        rv, st, fl;
    logic [31:0] np, rd;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rv = m_req && ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      np = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hFFFF_FFFC) : m_pc + 32'd4;
      rd = rv ? mem_word(m_pc) : $urandom();
      cycle(0, rv, rd, st, fl, np);
      n_checks++;
      if ({pcF, imem_addr, imem_req, instrD, pcD, validD, imem_timeout} !==
          {m_pc, m_pc, m_req, m_instr, m_pcd, m_valid, m_to}) begin
        n_fail++;
        $display("FAIL random[%0d]: pcF=%h addr=%h req=%b instrD=%h pcD=%h v=%b to=%b, want %h %h %b %h %h %b %b",
                 c, pcF, imem_addr, imem_req, instrD, pcD, validD, imem_timeout,
                 m_pc, m_pc, m_req, m_instr, m_pcd, m_valid, m_to);
      end
      if (validD === 1'b1) begin
        n_checks++;
        if (instrD !== mem_word(pcD)) begin
          n_fail++;
          $display("FAIL random_content[%0d]: instrD=%h for pcD=%h, want %h", c, instrD, pcD, mem_word(pcD));
        end
      end
    end
  endtask

  initial begin
    rst = 1; stallD = 0; flushD = 0; imem_rvalid = 0; imem_rdata = 0; npc = 0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_branch_wait();
    test_stall_hold();
    test_flush_adv();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds pcF and issues one instruction-memory read at a time.
- Consumes npc, which the decode stage computes from pcF and instrD.
- Delivers instrD/pcD/validD to the decode stage; this is the producer end of the pcF/instrD/npc loop.
- Supports variable-latency memory, hazard stall, flush, and a fetch-timeout flag.

Parameters:
- RESET_PC, 32'h0000_3000, pcF value after reset.
- TIMEOUT, 255, max cycles a request may wait for imem_rvalid before imem_timeout sets (1..255).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- npc  input  32  next PC from decode stage (valid every cycle).
- stallD  input  1  hazard unit: hold IF/ID register and pcF.
- flushD  input  1  hazard unit: squash IF/ID contents.
- imem_rvalid  input  1  memory read data valid; completes current request.
- imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
- imem_req  output  1  request outstanding.
- imem_addr  output  32  word address = pcF; stable while imem_req=1.
- pcF  output  32  PC being fetched.
- instrD  output  32  instruction in decode.
- pcD  output  32  PC of instrD.
- validD  output  1  instrD is new this cycle; decode squashes Regfile_weD/DataMem_weD when 0.
- imem_timeout  output  1  sticky: a request exceeded TIMEOUT cycles.

Behaviour:
- Reset (rst=1 at edge): pcF=RESET_PC, instrD=0, pcD=0, validD=0, imem_timeout=0, wait counter=0, skid buffer empty, state=REQ.
  - imem_req is 0 during the reset cycle and 1 in the first cycle after rst falls.
- Memory is reset by the same rst, so no response from a pre-reset request may arrive after reset.
- States:
  - REQ: imem_req=1, imem_addr=pcF.
  - HOLD: response buffered in skid, stallD active; imem_req=0.
- Advance: define adv = (REQ & imem_rvalid & ~stallD) | (HOLD & ~stallD).
  - On adv: instrD<=data (rdata in REQ, skid in HOLD), pcD<=pcF, validD<=1, pcF<=npc, state=REQ.
  - npc is sampled while the previous instrD (e.g. branch) is still in decode, giving delay-slot semantics.
- REQ & imem_rvalid & stallD: skid<=imem_rdata, state=HOLD. pcF and the D register are held; validD<=0 (the already-presented instruction is not re-issued).
- REQ & ~imem_rvalid: pcF and the D register are held, validD<=0 (bubble). instrD is NOT cleared, so npc stays correct for a pending branch.
- stallD with no new data: everything is held, validD<=0.
- Zero-wait memory (rvalid in the same cycle as req) sustains 1 instruction/cycle.
- flushD (highest priority after rst): instrD<=0, pcD<=0, validD<=0.
  - If flushD coincides with adv, the fetched word is discarded, but pcF<=npc and state=REQ still apply.
  - If flushD arrives in HOLD, the skid is kept.
- Timeout: the counter increments each cycle in REQ with imem_rvalid=0, saturating at TIMEOUT.
  - It clears on imem_rvalid.
  - When the counter reaches TIMEOUT, imem_timeout<=1 and stays set until rst. Fetching continues.
- imem_addr[1:0] is always 0. The block performs no misalignment check, since npc from decode is word-aligned.
- At most one request is outstanding. After rvalid, the next request's address appears in the following cycle.

Test Plan:
- Reset then zero-wait memory returning 0x24080001, 0x24090002, 0x240A0003:
  - pcF sequence 0x3000, 0x3004, 0x3008.
  - instrD arrives one cycle later with pcD matching and validD=1 on consecutive cycles.
- Memory latency 3 cycles per fetch:
  - imem_req stays high with imem_addr stable for 3 cycles.
  - validD pulses once per 3 cycles; instrD is held between pulses.
- beq at 0x3000 (taken, target 0x3010), delay slot returns after 4 wait cycles:
  - beq stays in instrD during the wait.
  - When the slot lands, pcF becomes 0x3010 and pcD=0x3004.
- rvalid with stallD=1 for 2 cycles:
  - state goes to HOLD, imem_req=0, no advance.
  - On stall release, instrD equals the buffered word, validD=1, pcF<=npc.
- flushD coinciding with rvalid:
  - instrD=0, validD=0.
  - pcF still advances to npc.
- No rvalid for 255 cycles:
  - imem_timeout rises on reaching 255, stays 1 after a later rvalid, and clears only on rst.
- rst asserted mid-request:
  - next cycle pcF=0x3000, instrD=0, validD=0, imem_req=0.
  - imem_req=1 the cycle after rst falls.
